i2c_eeprom_seq: RTL and testbench

//  Sequences the I2C byte-level phy to perform single-byte random writes and reads on a
//  24-series EEPROM (7-bit device address, 16-bit memory address). Accepts one host command
//  at a time, issues start/write/read/stop requests to the phy, checks slave acks, and

---
 rtl/i2c_pkg.sv | 54 +++++
 rtl/i2c_eeprom_seq.sv | 148 ++++++++++++++
 tb/tb_i2c_eeprom_seq.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared types for the I2C EEPROM sequencer: FSM states, phy op codes, command payload.
package i2c_pkg;

  localparam logic I2C_WR = 1'b0;
  localparam logic I2C_RD = 1'b1;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_DEV_W,
    ST_ADDR_HI,
    ST_ADDR_LO,
    ST_WDATA,
    ST_STOP,
    ST_POLL_START,
    ST_POLL_DEV,
    ST_POLL_STOP,
    ST_RESTART,
    ST_DEV_R,
    ST_RDATA,
    ST_ERR_STOP,
    ST_DONE
  } state_t;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_START,
    OP_STOP,
    OP_WRITE,
    OP_READ
  } phy_op_t;

  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  // Phy operation each state issues on entry
  function automatic phy_op_t state_op(input state_t s);
    case (s)
      ST_START, ST_POLL_START, ST_RESTART:                          return OP_START;
      ST_STOP, ST_POLL_STOP, ST_ERR_STOP:                           return OP_STOP;
      ST_DEV_W, ST_ADDR_HI, ST_ADDR_LO, ST_WDATA, ST_POLL_DEV,
      ST_DEV_R:                                                     return OP_WRITE;
      ST_RDATA:                                                     return OP_READ;
      default:                                                      return OP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/i2c_eeprom_seq.sv
// Single-byte random write/read sequencer for a 24-series EEPROM on top of a byte-level I2C phy.
module i2c_eeprom_seq
  import i2c_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR   = 7'h50,
  parameter int unsigned ADDR_BYTES = 2,
  parameter logic [7:0]  POLL_MAX   = 8'd255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rw,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              phy_start_req,
  output logic              phy_stop_req,
  output logic              phy_write_req,
  output logic              phy_read_req,
  input  logic              phy_ready,
  output logic              phy_master_ack,
  input  logic              phy_slave_ack,
  output logic [DATA_W-1:0] phy_wdata,
  input  logic [DATA_W-1:0] phy_rdata
);

  state_t            state, state_nxt;
  logic              wait_q, wait_nxt;
  cmd_t              cmd_q;
  logic [7:0]        poll_cnt;
  logic              poll_ack_q;
  logic              accept;
  logic              op_done;
  phy_op_t           op_nxt;
  logic [DATA_W-1:0] wbyte_nxt;
  logic              cmd_ready_d;
  logic              rsp_valid_d;
  logic              rsp_err_d;

  assign accept         = (state == ST_IDLE) && cmd_valid;
  assign op_done        = wait_q && phy_ready;
  assign phy_master_ack = 1'b0;

  // State register plus the "waiting for phy_ready" flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      wait_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      wait_q <= wait_nxt;
    end
  end

  // Next-state: each op state fires once, then waits for the phy completion pulse
  always_comb begin
    state_nxt = state;
    wait_nxt  = 1'b0;
    if (state_op(state) != OP_NONE) begin
      wait_nxt = !op_done;
    end
    case (state)
      ST_IDLE:       if (cmd_valid) state_nxt = ST_START;
      ST_START:      if (op_done) state_nxt = ST_DEV_W;
      ST_DEV_W:      if (op_done) state_nxt = !phy_slave_ack ? ST_ERR_STOP :
                                              (ADDR_BYTES == 2) ? ST_ADDR_HI : ST_ADDR_LO;
      ST_ADDR_HI:    if (op_done) state_nxt = phy_slave_ack ? ST_ADDR_LO : ST_ERR_STOP;
      ST_ADDR_LO:    if (op_done) state_nxt = !phy_slave_ack ? ST_ERR_STOP :
                                              (cmd_q.rw == I2C_RD) ? ST_RESTART : ST_WDATA;
      ST_WDATA:      if (op_done) state_nxt = phy_slave_ack ? ST_STOP : ST_ERR_STOP;
      ST_STOP:       if (op_done) state_nxt = (cmd_q.rw == I2C_RD) ? ST_DONE : ST_POLL_START;
      ST_POLL_START: if (op_done) state_nxt = ST_POLL_DEV;
      ST_POLL_DEV:   if (op_done) state_nxt = ST_POLL_STOP;
      ST_POLL_STOP:  if (op_done) state_nxt = (poll_ack_q || (poll_cnt == POLL_MAX)) ?
                                              ST_DONE : ST_POLL_START;
      ST_RESTART:    if (op_done) state_nxt = ST_DEV_R;
      ST_DEV_R:      if (op_done) state_nxt = phy_slave_ack ? ST_RDATA : ST_ERR_STOP;
      ST_RDATA:      if (op_done) state_nxt = ST_STOP;
      ST_ERR_STOP:   if (op_done) state_nxt = ST_DONE;
      ST_DONE:       state_nxt = ST_IDLE;
      default:       state_nxt = ST_IDLE;
    endcase
  end

  // Output decode from the upcoming state so every output can be registered
  always_comb begin
    op_nxt      = wait_nxt ? OP_NONE : state_op(state_nxt);
    wbyte_nxt   = phy_wdata;
    cmd_ready_d = (state_nxt == ST_IDLE);
    rsp_valid_d = (state_nxt == ST_DONE);
    rsp_err_d   = (state_nxt == ST_DONE) &&
                  ((state == ST_ERR_STOP) || ((state == ST_POLL_STOP) && !poll_ack_q));
    if (op_nxt == OP_WRITE) begin
      case (state_nxt)
        ST_DEV_W, ST_POLL_DEV: wbyte_nxt = {DEV_ADDR, I2C_WR};
        ST_DEV_R:              wbyte_nxt = {DEV_ADDR, I2C_RD};
        ST_ADDR_HI:            wbyte_nxt = cmd_q.addr[15:8];
        ST_ADDR_LO:            wbyte_nxt = cmd_q.addr[7:0];
        ST_WDATA:              wbyte_nxt = cmd_q.wdata;
        default:               wbyte_nxt = phy_wdata;
      endcase
    end
  end

  // Registered outputs, command latch, poll counter and read capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phy_start_req <= 1'b0;
      phy_stop_req  <= 1'b0;
      phy_write_req <= 1'b0;
      phy_read_req  <= 1'b0;
      phy_wdata     <= 8'hFF;
      cmd_ready     <= 1'b1;
      rsp_valid     <= 1'b0;
      rsp_err       <= 1'b0;
      rsp_rdata     <= 8'h00;
      cmd_q         <= '0;
      poll_cnt      <= 8'd0;
      poll_ack_q    <= 1'b0;
    end else begin
      phy_start_req <= (op_nxt == OP_START);
      phy_stop_req  <= (op_nxt == OP_STOP);
      phy_write_req <= (op_nxt == OP_WRITE);
      phy_read_req  <= (op_nxt == OP_READ);
      phy_wdata     <= wbyte_nxt;
      cmd_ready     <= cmd_ready_d;
      rsp_valid     <= rsp_valid_d;
      rsp_err       <= rsp_err_d;
      if (accept) begin
        cmd_q.rw    <= cmd_rw;
        cmd_q.addr  <= cmd_addr;
        cmd_q.wdata <= cmd_wdata;
        poll_cnt    <= 8'd0;
      end
      if ((state == ST_POLL_DEV) && op_done) begin
        poll_ack_q <= phy_slave_ack;
        if (!phy_slave_ack) poll_cnt <= poll_cnt + 8'd1;
      end
      if ((state == ST_RDATA) && op_done) begin
        rsp_rdata <= phy_rdata;
      end
    end
  end

endmodule

// File: tb/tb_i2c_eeprom_seq.sv
// Directed bench for i2c_eeprom_seq with a behavioural byte-level phy per DUT instance.
module tb_i2c_eeprom_seq;

  localparam int unsigned LAT  = 2;
  localparam logic [11:0] EV_S = 12'h100;
  localparam logic [11:0] EV_P = 12'h200;
  localparam logic [11:0] EV_R = 12'h400;
  localparam logic [23:0] OBS_RST = 24'h8000FF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        cmd_valid [2];
  logic        cmd_rw    [2];
  logic [15:0] cmd_addr  [2];
  logic [7:0]  cmd_wdata [2];
  logic [31:0] nack_mask [2];
  logic [7:0]  rd_cfg    [2];
  logic        spur_rdy  [2];

  int n_checks = 0;
  int n_pass   = 0;
  logic [11:0] exp_q [$];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic        cmd_ready, rsp_valid, rsp_err;
    logic [7:0]  rsp_rdata, wdata, rdata;
    logic        start_req, stop_req, write_req, read_req, master_ack;
    logic        slave_ack, ready, mdl_rdy, busy;
    logic [23:0] obs;
    logic [11:0] ev_log [256];
    int          ev_n = 0;
    int          rsp_n = 0;
    int          rsp_w = 0;
    int          rsp_wmax = 0;
    int unsigned lat_cnt;
    int unsigned wr_cnt;

    assign ready = mdl_rdy | spur_rdy[g];
    assign obs   = {cmd_ready, rsp_valid, rsp_err, start_req, stop_req, write_req,
                    read_req, master_ack, rsp_rdata, wdata};

    i2c_eeprom_seq #(
      .DEV_ADDR  (7'h50),
      .ADDR_BYTES(g == 0 ? 2 : 1),
      .POLL_MAX  (g == 0 ? 8'd255 : 8'd2)
    ) u_dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .cmd_valid     (cmd_valid[g]),
      .cmd_ready     (cmd_ready),
      .cmd_rw        (cmd_rw[g]),
      .cmd_addr      (cmd_addr[g]),
      .cmd_wdata     (cmd_wdata[g]),
      .rsp_valid     (rsp_valid),
      .rsp_err       (rsp_err),
      .rsp_rdata     (rsp_rdata),
      .phy_start_req (start_req),
      .phy_stop_req  (stop_req),
      .phy_write_req (write_req),
      .phy_read_req  (read_req),
      .phy_ready     (ready),
      .phy_master_ack(master_ack),
      .phy_slave_ack (slave_ack),
      .phy_wdata     (wdata),
      .phy_rdata     (rdata)
    );

    // Phy model: logs each request, answers LAT+1 cycles later with programmed ack/data
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mdl_rdy   <= 1'b0;
        busy      <= 1'b0;
        lat_cnt   <= 0;
        wr_cnt    <= 0;
        slave_ack <= 1'b0;
        rdata     <= 8'h00;
      end else begin
        mdl_rdy <= 1'b0;
        if (rsp_valid) wr_cnt <= 0;
        if (start_req || stop_req || write_req || read_req) begin
          ev_log[ev_n[7:0]] <= start_req ? EV_S : stop_req ? EV_P :
                               write_req ? {4'h3, wdata} : {4'h4, 7'd0, master_ack};
          ev_n    <= ev_n + 1;
          busy    <= 1'b1;
          lat_cnt <= LAT;
          if (write_req) begin
            slave_ack <= !nack_mask[g][wr_cnt[4:0]];
            wr_cnt    <= wr_cnt + 1;
          end
          if (read_req) rdata <= rd_cfg[g];
        end else if (busy) begin
          if (lat_cnt == 0) begin
            mdl_rdy <= 1'b1;
            busy    <= 1'b0;
          end else begin
            lat_cnt <= lat_cnt - 1;
          end
        end
      end
    end

    // Response monitor: counts responses and the widest rsp_valid pulse
    always @(posedge clk) begin
      if (rsp_valid) begin
        rsp_w <= rsp_w + 1;
        if (rsp_w + 1 > rsp_wmax) rsp_wmax <= rsp_w + 1;
        if (rsp_w == 0) rsp_n <= rsp_n + 1;
      end else begin
        rsp_w <= 0;
      end
    end
  end

  function automatic logic [23:0] get_obs(input int inst);
    if (inst == 0) return g_dut[0].obs;
    return g_dut[1].obs;
  endfunction

  function automatic int get_ev_n(input int inst);
    if (inst == 0) return g_dut[0].ev_n;
    return g_dut[1].ev_n;
  endfunction

  function automatic logic [11:0] get_ev(input int inst, input int idx);
    if (inst == 0) return g_dut[0].ev_log[idx[7:0]];
    return g_dut[1].ev_log[idx[7:0]];
  endfunction

  function automatic logic [11:0] ew(input logic [7:0] b);
    return {4'h3, b};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic ex(input logic [11:0] e);
    exp_q.push_back(e);
  endtask

  task automatic chk_seq(input string tag, input int inst, input int base);
    check({tag, "_nev"}, 32'(get_ev_n(inst) - base), 32'(exp_q.size()));
    foreach (exp_q[i])
      check($sformatf("%s_ev%0d", tag, i), 32'(get_ev(inst, base + i)), 32'(exp_q[i]));
  endtask

  // Issue one command and wait (bounded) for its response pulse
  task automatic run_cmd(input int inst, input logic rw, input logic [15:0] addr,
                         input logic [7:0] wd, input logic hold, input string tag,
                         output logic err, output logic [7:0] rdat);
    logic [23:0] o;
    bit seen;
    @(negedge clk);
    cmd_valid[inst] = 1'b1;
    cmd_rw[inst]    = rw;
    cmd_addr[inst]  = addr;
    cmd_wdata[inst] = wd;
    @(negedge clk);
    o = get_obs(inst);
    if (!hold) cmd_valid[inst] = 1'b0;
    check({tag, "_lat"}, 32'({o[23], o[20]}), 32'(2'b01));
    seen = 1'b0;
    err  = 1'bx;
    rdat = 8'hxx;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      o = get_obs(inst);
      if (o[22]) begin
        seen = 1'b1;
        err  = o[21];
        rdat = o[15:8];
        cmd_valid[inst] = 1'b0;
        check({tag, "_busy"}, 32'(o[23]), 32'd0);
      end
    end
    check({tag, "_rsp"}, 32'(seen), 32'd1);
    @(negedge clk);
    o = get_obs(inst);
    check({tag, "_idle"}, 32'({o[23], o[22]}), 32'(2'b10));
  endtask

  initial begin
    logic       err;
    logic [7:0] rd;
    int         base;
    int         rbase;
    bit         hit;
    for (int i = 0; i < 2; i++) begin
      cmd_valid[i] = 1'b0;
      cmd_rw[i]    = 1'b0;
      cmd_addr[i]  = 16'h0;
      cmd_wdata[i] = 8'h0;
      nack_mask[i] = 32'h0;
      rd_cfg[i]    = 8'h0;
      spur_rdy[i]  = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_obs0", 32'(get_obs(0)), 32'(OBS_RST));
    check("rst_obs1", 32'(get_obs(1)), 32'(OBS_RST));
    rst_n = 1'b1;
    @(negedge clk);

    // Spurious phy_ready in IDLE
    base = get_ev_n(0);
    spur_rdy[0] = 1'b1;
    @(negedge clk);
    spur_rdy[0] = 1'b0;
    repeat (3) @(negedge clk);
    check("spur_nev", 32'(get_ev_n(0) - base), 32'd0);
    check("spur_obs", 32'(get_obs(0)), 32'(OBS_RST));

    // Write 0x1234 <= 0xA5, all ACK
    base = get_ev_n(0);
    run_cmd(0, 1'b0, 16'h1234, 8'hA5, 1'b0, "wr", err, rd);
    check("wr_err", 32'(err), 32'd0);
    exp_q.delete();
    ex(EV_S); ex(ew(8'hA0)); ex(ew(8'h12)); ex(ew(8'h34)); ex(ew(8'hA5)); ex(EV_P);
    ex(EV_S); ex(ew(8'hA0)); ex(EV_P);
    chk_seq("wr", 0, base);
    check("wr_pulse_w", 32'(g_dut[0].rsp_wmax), 32'd1);

    // Read 0x00FF, slave returns 0x3C
    rd_cfg[0] = 8'h3C;
    base = get_ev_n(0);
    run_cmd(0, 1'b1, 16'h00FF, 8'h00, 1'b0, "rd", err, rd);
    check("rd_err", 32'(err), 32'd0);
    check("rd_data", 32'(rd), 32'h3C);
    exp_q.delete();
    ex(EV_S); ex(ew(8'hA0)); ex(ew(8'h00)); ex(ew(8'hFF)); ex(EV_S); ex(ew(8'hA1));
    ex(EV_R); ex(EV_P);
    chk_seq("rd", 0, base);

    // Device NACK on the address byte
    nack_mask[0] = 32'h1;
    base = get_ev_n(0);
    run_cmd(0, 1'b0, 16'h0010, 8'h55, 1'b0, "dnack", err, rd);
    check("dnack_err", 32'(err), 32'd1);
    exp_q.delete();
    ex(EV_S); ex(ew(8'hA0)); ex(EV_P);
    chk_seq("dnack", 0, base);

    // Poll NACKed three times, then ACK
    nack_mask[0] = 32'h70;
    base = get_ev_n(0);
    run_cmd(0, 1'b0, 16'h0200, 8'h11, 1'b0, "poll", err, rd);
    check("poll_err", 32'(err), 32'd0);
    exp_q.delete();
    ex(EV_S); ex(ew(8'hA0)); ex(ew(8'h02)); ex(ew(8'h00)); ex(ew(8'h11)); ex(EV_P);
    for (int k = 0; k < 4; k++) begin
      ex(EV_S); ex(ew(8'hA0)); ex(EV_P);
    end
    chk_seq("poll", 0, base);

    // cmd_valid held through the busy period: one command only
    nack_mask[0] = 32'h0;
    base  = get_ev_n(0);
    rbase = g_dut[0].rsp_n;
    run_cmd(0, 1'b0, 16'h0003, 8'h77, 1'b1, "hold", err, rd);
    repeat (20) @(negedge clk);
    check("hold_nev", 32'(get_ev_n(0) - base), 32'd9);
    check("hold_nrsp", 32'(g_dut[0].rsp_n - rbase), 32'd1);

    // Single address byte: read 0x0042
    rd_cfg[1] = 8'h5A;
    base = get_ev_n(1);
    run_cmd(1, 1'b1, 16'h0042, 8'h00, 1'b0, "rd1", err, rd);
    check("rd1_err", 32'(err), 32'd0);
    check("rd1_data", 32'(rd), 32'h5A);
    exp_q.delete();
    ex(EV_S); ex(ew(8'hA0)); ex(ew(8'h42)); ex(EV_S); ex(ew(8'hA1)); ex(EV_R); ex(EV_P);
    chk_seq("rd1", 1, base);

    // Poll exhaustion with POLL_MAX = 2
    nack_mask[1] = 32'hFFFF_FFF8;
    base = get_ev_n(1);
    run_cmd(1, 1'b0, 16'h0007, 8'h99, 1'b0, "pmax", err, rd);
    check("pmax_err", 32'(err), 32'd1);
    exp_q.delete();
    ex(EV_S); ex(ew(8'hA0)); ex(ew(8'h07)); ex(ew(8'h99)); ex(EV_P);
    for (int k = 0; k < 2; k++) begin
      ex(EV_S); ex(ew(8'hA0)); ex(EV_P);
    end
    chk_seq("pmax", 1, base);

    // Reset asserted while waiting on the data byte
    base = get_ev_n(0);
    @(negedge clk);
    cmd_valid[0] = 1'b1;
    cmd_rw[0]    = 1'b0;
    cmd_addr[0]  = 16'h0555;
    cmd_wdata[0] = 8'hC3;
    @(negedge clk);
    cmd_valid[0] = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 500 && !hit; i++) begin
      @(negedge clk);
      if (get_ev_n(0) >= base + 5) hit = 1'b1;
    end
    check("mid_reach", 32'(hit), 32'd1);
    check("mid_wbyte", 32'(get_ev(0, base + 4)), 32'(ew(8'hC3)));
    rst_n = 1'b0;
    #1;
    check("mid_rst_obs", 32'(get_obs(0)), 32'(OBS_RST));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rd_cfg[0] = 8'h96;
    run_cmd(0, 1'b1, 16'h0100, 8'h00, 1'b0, "post", err, rd);
    check("post_err", 32'(err), 32'd0);
    check("post_data", 32'(rd), 32'h96);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d so far", n_pass, n_checks);
    $fatal(1);
  end

endmodule
